// File: rtl/bitstream_fetch.sv
// bitstream_fetch
//   Reconfiguration bitstream fetch engine. On a start request it reads
//   word_count 32-bit words from memory over the xbs bus. It issues one read
//   at a time and only when the word buffer has room for the returned word.
//   The words are buffered in a small first-word-fall-through FIFO. From
//   there they are streamed to an ICAP-style port with a valid/ready handshake.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle fetch request (ignored while busy)
//   base_addr           : byte address of first word (low two bits dropped)
//   word_count          : number of words to fetch (0 allowed)
//   xbs_select/addr     : read request strobe and word-aligned address
//   xbs_data/rnw/be     : constant read-only bus attributes
//   sl_ack/sl_data      : read acknowledge and returned data
//   icap_data/valid     : FIFO head word / FIFO not empty
//   icap_ready          : downstream accepts the head word
//   busy/done/error     : fetch in progress, completion pulse, sticky timeout
module bitstream_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    output logic        xbs_select,
    output logic [31:0] xbs_addr,
    output logic [31:0] xbs_data,
    output logic        xbs_rnw,
    output logic [3:0]  xbs_be,
    input  logic        sl_ack,
    input  logic [31:0] sl_data,
    output logic [31:0] icap_data,
    output logic        icap_valid,
    input  logic        icap_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [15:0]      r_remaining;
    logic [TMO_W-1:0] r_tmo;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_has_slot;

    // Acks are only meaningful while a request is outstanding.
    assign w_push     = (r_state == S_WAIT_ACK) && sl_ack;
    assign w_pop      = icap_valid && icap_ready;
    assign w_flush    = (r_state == S_ERR);
    assign w_has_slot = (r_count < DEPTH_C);

    assign icap_valid = (r_count != '0);
    // Hold the data output at zero while empty so it never shows stale or
    // uninitialised storage.
    assign icap_data  = icap_valid ? r_mem[r_rd_ptr] : 32'd0;

    assign xbs_data = 32'd0;
    assign xbs_rnw  = 1'b1;
    assign xbs_be   = 4'b1111;

    // FIFO storage: plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sl_data;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave
    // the count unchanged. A flush wins over both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Fetch control FSM with registered bus and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_tmo       <= '0;
            xbs_select  <= 1'b0;
            xbs_addr    <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= {base_addr[31:2], 2'b00};
                        r_remaining <= word_count;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= (word_count == 16'd0) ? S_DRAIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Only request a word when its landing slot is guaranteed.
                    // The one-cycle stay here also gives the mandatory
                    // select-low gap between requests.
                    if (w_has_slot) begin
                        xbs_select <= 1'b1;
                        xbs_addr   <= r_addr;
                        r_tmo      <= '0;
                        r_state    <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (sl_ack) begin
                        xbs_select  <= 1'b0;
                        r_addr      <= r_addr + 32'd4;
                        r_remaining <= r_remaining - 16'd1;
                        r_state     <= (r_remaining == 16'd1) ? S_DRAIN : S_ISSUE;
                    end else if (r_tmo == TMO_LAST) begin
                        xbs_select <= 1'b0;
                        r_state    <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!icap_valid) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    error   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitstream_fetch.sv
module tb_bitstream_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] word_count = 16'd0;
    logic        xbs_select;
    logic [31:0] xbs_addr;
    logic [31:0] xbs_data;
    logic        xbs_rnw;
    logic [3:0]  xbs_be;
    logic        sl_ack;
    logic [31:0] sl_data;
    logic [31:0] icap_data;
    logic        icap_valid;
    logic        icap_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;

    // memory responder controls (written only by the test sequence)
    int ack_delay = 3;
    bit never_ack = 1'b0;

    // monitor state (written only by the monitors)
    logic [31:0] read_q[$];
    logic [31:0] out_q[$];
    int          sel_cycles = 0;
    int          done_cnt = 0;
    bit          prev_sel = 1'b0;
    bit          pending = 1'b0;
    int          wcnt = 0;
    logic [31:0] ack_addr = 32'd0;

    bitstream_fetch #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .xbs_select(xbs_select), .xbs_addr(xbs_addr),
        .xbs_data(xbs_data), .xbs_rnw(xbs_rnw), .xbs_be(xbs_be),
        .sl_ack(sl_ack), .sl_data(sl_data), .icap_data(icap_data),
        .icap_valid(icap_valid), .icap_ready(icap_ready), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Memory model: once a request is seen, ack it ack_delay sampled cycles
    // later with data = address ^ 0x5A5A0000. A request in flight is answered
    // even if the requester was reset meanwhile (late ack).
    initial begin
        sl_ack  = 1'b0;
        sl_data = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            sl_ack = 1'b0;
            if (xbs_select) sel_cycles++;
            if (xbs_select && !prev_sel) read_q.push_back(xbs_addr);
            prev_sel = xbs_select;
            if (!pending && xbs_select && !never_ack) begin
                pending  = 1'b1;
                wcnt     = 0;
                ack_addr = xbs_addr;
            end
            if (pending) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    sl_ack  = 1'b1;
                    sl_data = ack_addr ^ 32'h5A5A_0000;
                    pending = 1'b0;
                end
            end
        end
    end

    // ICAP side monitor
    always @(negedge clk) begin
        if (!rst && icap_valid && icap_ready) out_q.push_back(icap_data);
        if (!rst && done) done_cnt++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        @(posedge clk);
        #1;
        base_addr  = a;
        word_count = n;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(posedge clk);
            #1;
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({xbs_select, busy, done, error, icap_valid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got sel/busy/done/err/valid=%b want 00000",
                     {xbs_select, busy, done, error, icap_valid});
        end
        total++;
        if (xbs_addr !== 32'd0 || icap_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h icap=%h want 0/0", xbs_addr, icap_data);
        end
        total++;
        if ({xbs_rnw, xbs_be, xbs_data} !== {1'b1, 4'hF, 32'd0}) begin
            bad++;
            $display("FAIL bus_const: got rnw=%b be=%h data=%h want 1/f/0", xbs_rnw, xbs_be, xbs_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || icap_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got busy=%b valid=%b want 0/0", busy, icap_valid);
        end
        $display("test_reset: checked reset values");
    endtask

    task automatic test_basic();
        int  r0, o0, d0;
        bit  ok;
        logic [31:0] act;
        ack_delay = 3;
        icap_ready = 1'b1;
        r0 = read_q.size(); o0 = out_q.size(); d0 = done_cnt;
        pulse_start(32'h0000_0100, 16'd4);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(200, ok);
        total++;
        if (!ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: got done_seen=%0d busy=%b want 1/0", ok, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (read_q.size() - r0 != 4 || out_q.size() - o0 != 4) begin
            bad++;
            $display("FAIL basic_counts: got reads=%0d words=%0d want 4/4",
                     read_q.size() - r0, out_q.size() - o0);
        end
        for (int i = 0; i < 4; i++) begin
            act = (r0 + i < read_q.size()) ? read_q[r0 + i] : 32'hDEAD_DEAD;
            total++;
            if (act !== 32'h0000_0100 + 32'(4 * i)) begin
                bad++;
                $display("FAIL basic_addr[%0d]: got %h want %h", i, act, 32'h0000_0100 + 32'(4 * i));
            end
            act = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hDEAD_DEAD;
            total++;
            if (act !== 32'h5A5A_0100 + 32'(4 * i)) begin
                bad++;
                $display("FAIL basic_data[%0d]: got %h want %h", i, act, 32'h5A5A_0100 + 32'(4 * i));
            end
        end
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt - d0);
        end
        $display("test_basic: base=0x100 n=4 reads=%0d words=%0d", read_q.size() - r0, out_q.size() - o0);
    endtask

    task automatic test_zero_count();
        int s0;
        s0 = sel_cycles;
        pulse_start(32'h0000_0040, 16'd0);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL zero_cycle1: got busy=%b done=%b want 1/0", busy, done);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL zero_cycle2: got done=%b busy=%b err=%b want 1/0/0", done, busy, error);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || sel_cycles != s0) begin
            bad++;
            $display("FAIL zero_after: got done=%b sel_cycles=%0d want 0/0", done, sel_cycles - s0);
        end
        $display("test_zero_count: n=0 done two cycles after start");
    endtask

    task automatic test_backpressure();
        int  r0, o0;
        bit  ok;
        logic [31:0] act;
        ack_delay = 3;
        icap_ready = 1'b0;
        r0 = read_q.size(); o0 = out_q.size();
        pulse_start(32'h0000_0200, 16'd8);
        repeat (60) @(posedge clk);
        #1;
        total++;
        if (read_q.size() - r0 != 4 || xbs_select !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall: got reads=%0d sel=%b want 4/0", read_q.size() - r0, xbs_select);
        end
        total++;
        if (icap_valid !== 1'b1 || icap_data !== 32'h5A5A_0200 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_head: got valid=%b data=%h busy=%b want 1/5a5a0200/1", icap_valid, icap_data, busy);
        end
        icap_ready = 1'b1;
        wait_done(400, ok);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (!ok || read_q.size() - r0 != 8 || out_q.size() - o0 != 8) begin
            bad++;
            $display("FAIL bp_resume: got done_seen=%0d reads=%0d words=%0d want 1/8/8",
                     ok, read_q.size() - r0, out_q.size() - o0);
        end
        for (int i = 0; i < 8; i++) begin
            act = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hDEAD_DEAD;
            total++;
            if (act !== 32'h5A5A_0200 + 32'(4 * i)) begin
                bad++;
                $display("FAIL bp_data[%0d]: got %h want %h", i, act, 32'h5A5A_0200 + 32'(4 * i));
            end
        end
        $display("test_backpressure: base=0x200 n=8 words=%0d", out_q.size() - o0);
    endtask

    task automatic test_timeout();
        int  s0, d0, r0;
        bit  got;
        bit  ok;
        never_ack = 1'b1;
        s0 = sel_cycles; d0 = done_cnt; r0 = read_q.size();
        pulse_start(32'h0000_0300, 16'd3);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            if (error) got = 1'b1;
        end
        total++;
        if (!got || busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_error: got error_seen=%0d busy=%b want 1/0", got, busy);
        end
        total++;
        if (sel_cycles - s0 != 64 || read_q.size() - r0 != 1) begin
            bad++;
            $display("FAIL tmo_select: got sel_cycles=%0d reads=%0d want 64/1", sel_cycles - s0, read_q.size() - r0);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt != d0 || error !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky: got done_pulses=%0d error=%b want 0/1", done_cnt - d0, error);
        end
        never_ack = 1'b0;
        pulse_start(32'h0000_0300, 16'd0);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_clear: got error=%b busy=%b want 0/1", error, busy);
        end
        wait_done(10, ok);
        $display("test_timeout: select high %0d cycles, error then cleared", sel_cycles - s0);
    endtask

    task automatic test_reset_mid();
        int  r0, o0, o1, d0;
        bit  got;
        bit  ok;
        logic [31:0] act;
        ack_delay = 10;
        icap_ready = 1'b1;
        r0 = read_q.size();
        pulse_start(32'h0000_0400, 16'd6);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (read_q.size() - r0 >= 2) got = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (!got || {xbs_select, busy, done, error, icap_valid} !== 5'b0 || xbs_addr !== 32'd0) begin
            bad++;
            $display("FAIL midrst_async: got word2_seen=%0d flags=%b addr=%h want 1/00000/0",
                     got, {xbs_select, busy, done, error, icap_valid}, xbs_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        o1 = out_q.size(); d0 = done_cnt;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (icap_valid !== 1'b0 || busy !== 1'b0 || out_q.size() != o1 || done_cnt != d0) begin
            bad++;
            $display("FAIL midrst_late_ack: got valid=%b busy=%b words=%0d done=%0d want 0/0/0/0",
                     icap_valid, busy, out_q.size() - o1, done_cnt - d0);
        end
        ack_delay = 3;
        r0 = read_q.size(); o0 = out_q.size();
        pulse_start(32'h0000_0500, 16'd2);
        wait_done(100, ok);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (!ok || read_q.size() - r0 != 2 || out_q.size() - o0 != 2) begin
            bad++;
            $display("FAIL midrst_refetch: got done_seen=%0d reads=%0d words=%0d want 1/2/2",
                     ok, read_q.size() - r0, out_q.size() - o0);
        end
        for (int i = 0; i < 2; i++) begin
            act = (o0 + i < out_q.size()) ? out_q[o0 + i] : 32'hDEAD_DEAD;
            total++;
            if (act !== 32'h5A5A_0500 + 32'(4 * i)) begin
                bad++;
                $display("FAIL midrst_data[%0d]: got %h want %h", i, act, 32'h5A5A_0500 + 32'(4 * i));
            end
        end
        $display("test_reset_mid: reset during word 2, refetch of 2 words");
    endtask

    task automatic test_wrap_and_ignore();
        int  r0, o0, d0;
        bit  ok;
        logic [31:0] act_a0, act_a1, act_d0, act_d1;
        ack_delay = 3;
        icap_ready = 1'b1;
        r0 = read_q.size(); o0 = out_q.size(); d0 = done_cnt;
        pulse_start(32'hFFFF_FFFF, 16'd2);
        repeat (2) @(posedge clk);
        #1;
        base_addr  = 32'h0000_0800;
        word_count = 16'd5;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, ok);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (!ok || read_q.size() - r0 != 2 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL wrap_counts: got done_seen=%0d reads=%0d pulses=%0d want 1/2/1",
                     ok, read_q.size() - r0, done_cnt - d0);
        end
        act_a0 = (r0 < read_q.size()) ? read_q[r0] : 32'hDEAD_DEAD;
        act_a1 = (r0 + 1 < read_q.size()) ? read_q[r0 + 1] : 32'hDEAD_DEAD;
        total++;
        if (act_a0 !== 32'hFFFF_FFFC || act_a1 !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", act_a0, act_a1);
        end
        act_d0 = (o0 < out_q.size()) ? out_q[o0] : 32'hDEAD_DEAD;
        act_d1 = (o0 + 1 < out_q.size()) ? out_q[o0 + 1] : 32'hDEAD_DEAD;
        total++;
        if (act_d0 !== 32'hA5A5_FFFC || act_d1 !== 32'h5A5A_0000) begin
            bad++;
            $display("FAIL wrap_data: got %h,%h want a5a5fffc,5a5a0000", act_d0, act_d1);
        end
        $display("test_wrap_and_ignore: reads %h %h", act_a0, act_a1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_wrap_and_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
